// File: rtl/varcic_mc.sv
// Multi-channel runtime-variable CIC decimator with auto shift, round-half-up and saturation.
// Latency: out_strobe/out_data 2 clocks after the in_strobe that completes a decimation.
// No backpressure: accepts one sample per clock for any R; outputs are single-cycle strobes.
module varcic_mc #(
    parameter int STAGES    = 5,
    parameter int IN_WIDTH  = 18,
    parameter int OUT_WIDTH = 18,
    parameter int DEC_WIDTH = 6,
    parameter int ACC_WIDTH = 48,
    parameter int CHANNELS  = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [DEC_WIDTH-1:0]            decimation,
    input  logic                            in_strobe,
    input  logic [CHANNELS*IN_WIDTH-1:0]    in_data,
    output logic                            out_strobe,
    output logic [CHANNELS*OUT_WIDTH-1:0]   out_data,
    output logic [DEC_WIDTH-1:0]            dec_active,
    output logic                            settling
);

    localparam int SH_W = $clog2(ACC_WIDTH + 1);
    localparam int WC_W = $clog2(STAGES + 1);
    localparam logic signed [ACC_WIDTH:0] SAT_HI =
        (ACC_WIDTH+1)'((64'sd1 <<< (OUT_WIDTH-1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH:0] SAT_LO =
        (ACC_WIDTH+1)'(-(64'sd1 <<< (OUT_WIDTH-1)));

    if (ACC_WIDTH < IN_WIDTH + STAGES*DEC_WIDTH) begin : g_acc_check
        $error("ACC_WIDTH must be >= IN_WIDTH + STAGES*DEC_WIDTH");
    end

    typedef logic signed [ACC_WIDTH-1:0] acc_t;

    acc_t                        in_ext   [CHANNELS];
    acc_t                        integ    [CHANNELS][STAGES];
    acc_t                        comb_q   [CHANNELS][STAGES];
    acc_t                        comb_dly [CHANNELS][STAGES];
    logic signed [OUT_WIDTH-1:0] rounded  [CHANNELS];
    logic [DEC_WIDTH-1:0]        count;
    logic                        comb_strobe;
    logic                        round_strobe;
    logic                        flush;
    logic                        accept;
    logic [WC_W-1:0]             warm;
    logic [SH_W-1:0]             shift;

    // A decimation change (including the first load after reset) flushes in the same cycle.
    assign flush  = (decimation != dec_active);
    assign accept = in_strobe && !flush && (dec_active != '0);

    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++)
            in_ext[ch] = acc_t'($signed(in_data[ch*IN_WIDTH +: IN_WIDTH]));
    end

    // ceil(log2(R)) is the position above the highest set bit of R-1.
    always_comb begin : shift_calc
        logic [DEC_WIDTH-1:0] r_m1;
        int                   lg;
        r_m1 = dec_active - DEC_WIDTH'(1);
        lg   = 0;
        for (int i = 0; i < DEC_WIDTH; i++)
            if (r_m1[i]) lg = i + 1;
        shift = SH_W'(STAGES * lg);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count        <= '0;
            comb_strobe  <= 1'b0;
            round_strobe <= 1'b0;
            dec_active   <= '0;
        end else if (flush) begin
            count        <= '0;
            comb_strobe  <= 1'b0;
            round_strobe <= 1'b0;
            dec_active   <= decimation;
        end else begin
            comb_strobe  <= 1'b0;
            round_strobe <= comb_strobe;
            if (accept) begin
                if (count == dec_active - DEC_WIDTH'(1)) begin
                    count       <= '0;
                    comb_strobe <= 1'b1;
                end else begin
                    count <= count + DEC_WIDTH'(1);
                end
            end
        end
    end

    // Integrators wrap modulo 2^ACC_WIDTH; the combs cancel the wrap exactly.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int ch = 0; ch < CHANNELS; ch++)
                for (int k = 0; k < STAGES; k++)
                    integ[ch][k] <= '0;
        end else if (accept) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                integ[ch][0] <= integ[ch][0] + in_ext[ch];
                for (int k = 1; k < STAGES; k++)
                    integ[ch][k] <= integ[ch][k] + integ[ch][k-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int ch = 0; ch < CHANNELS; ch++)
                for (int k = 0; k < STAGES; k++) begin
                    comb_q[ch][k]   <= '0;
                    comb_dly[ch][k] <= '0;
                end
        end else if (comb_strobe) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                comb_q[ch][0]   <= integ[ch][STAGES-1] - comb_dly[ch][0];
                comb_dly[ch][0] <= integ[ch][STAGES-1];
                for (int k = 1; k < STAGES; k++) begin
                    comb_q[ch][k]   <= comb_q[ch][k-1] - comb_dly[ch][k];
                    comb_dly[ch][k] <= comb_q[ch][k-1];
                end
            end
        end
    end

    // Round half up: floor(y / 2^s) plus the last bit shifted out.
    always_comb begin : round_sat
        acc_t                    y;
        logic signed [ACC_WIDTH:0] t;
        y = '0;
        t = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            rounded[ch] = '0;
            y = comb_q[ch][STAGES-1];
            t = (ACC_WIDTH+1)'(y) >>> shift;
            if (shift != '0)
                t = t + {{ACC_WIDTH{1'b0}}, y[shift - SH_W'(1)]};
            if (t > SAT_HI)
                rounded[ch] = SAT_HI[OUT_WIDTH-1:0];
            else if (t < SAT_LO)
                rounded[ch] = SAT_LO[OUT_WIDTH-1:0];
            else
                rounded[ch] = t[OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_strobe <= 1'b0;
            out_data   <= '0;
            settling   <= 1'b1;
            warm       <= '0;
        end else if (flush) begin
            out_strobe <= 1'b0;
            settling   <= 1'b1;
            warm       <= '0;
        end else begin
            out_strobe <= 1'b0;
            if (round_strobe) begin
                if (warm != WC_W'(STAGES)) begin
                    warm <= warm + WC_W'(1);
                end else begin
                    out_strobe <= 1'b1;
                    settling   <= 1'b0;
                    for (int ch = 0; ch < CHANNELS; ch++)
                        out_data[ch*OUT_WIDTH +: OUT_WIDTH] <= rounded[ch];
                end
            end
        end
    end

endmodule

// File: tb/tb_varcic_mc.sv
// Bench for varcic_mc: random and directed stimulus against a direct-form CIC reference model.
module tb_varcic_mc;

    localparam int N  = 5;
    localparam int IW = 18;
    localparam int OW = 18;
    localparam int DW = 6;
    localparam int AW = 48;
    localparam int CH = 2;
    localparam int HMAX = 8192;

    logic              clock = 1'b0;
    logic              reset;
    logic [DW-1:0]     decimation;
    logic              in_strobe;
    logic [CH*IW-1:0]  in_data;
    logic              out_strobe;
    logic [CH*OW-1:0]  out_data;
    logic [DW-1:0]     dec_active;
    logic              settling;

    always #5 clock = ~clock;

    varcic_mc #(
        .STAGES(N), .IN_WIDTH(IW), .OUT_WIDTH(OW),
        .DEC_WIDTH(DW), .ACC_WIDTH(AW), .CHANNELS(CH)
    ) dut (
        .clock(clock), .reset(reset), .decimation(decimation),
        .in_strobe(in_strobe), .in_data(in_data),
        .out_strobe(out_strobe), .out_data(out_data),
        .dec_active(dec_active), .settling(settling)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Reference model: the CIC response is the length-R boxcar convolved with itself N times,
    // applied to the samples accepted since the last flush, with the pipeline's sample delay.
    int     m_r = 0;
    int     n_acc = 0;
    int     hist [CH][HMAX];
    longint h [1024];
    int     hlen = 1;
    bit     m_settling = 1'b1;
    longint m_out [CH];
    bit     q_stb [4];
    longint q_val [4][CH];
    int     cyc = 0;

    task automatic build_h(input int r);
        longint t [1024];
        hlen = 1;
        h[0] = 1;
        for (int s = 0; s < N; s++) begin
            for (int i = 0; i < hlen + r - 1; i++) t[i] = 0;
            for (int i = 0; i < hlen; i++)
                for (int j = 0; j < r; j++) t[i+j] += h[i];
            hlen = hlen + r - 1;
            for (int i = 0; i < hlen; i++) h[i] = t[i];
        end
    endtask

    function automatic int ceil_log2(input int r);
        int c = 0;
        while ((1 << c) < r) c++;
        return c;
    endfunction

    function automatic longint rnd_sat(input longint y, input int s);
        longint v;
        longint hi = (longint'(1) <<< (OW-1)) - 1;
        longint lo = -(longint'(1) <<< (OW-1));
        if (s == 0) v = y;
        else        v = (y + (longint'(1) <<< (s-1))) >>> s;
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return v;
    endfunction

    function automatic longint model_lane(input int ch, input int last);
        longint acc = 0;
        int base = last - m_r*(N-1) - (N-1);
        for (int i = 0; i < hlen; i++)
            if (base - i >= 0) acc += h[i] * longint'(hist[ch][base-i]);
        return rnd_sat(acc, N * ceil_log2(m_r));
    endfunction

    function automatic logic signed [63:0] lane(input int ch);
        return 64'($signed(out_data[ch*OW +: OW]));
    endfunction

    task automatic step(input bit rst, input int dec, input bit stb, input int d0, input int d1);
        int  now = cyc % 4;
        int  nxt = (cyc + 1) % 4;
        bit  e_stb;
        reset      = rst;
        decimation = DW'(dec);
        in_strobe  = stb;
        in_data    = {IW'(d1), IW'(d0)};
        if (rst || dec != m_r) begin
            q_stb[now] = 1'b0;
            q_stb[nxt] = 1'b0;
            m_settling = 1'b1;
            n_acc      = 0;
            if (rst) begin
                m_r = 0;
                for (int c = 0; c < CH; c++) m_out[c] = 0;
            end else begin
                m_r = dec;
                if (m_r != 0) build_h(m_r);
            end
        end else if (m_r != 0 && stb && n_acc < HMAX) begin
            hist[0][n_acc] = d0;
            hist[1][n_acc] = d1;
            n_acc++;
            if (n_acc % m_r == 0 && (n_acc / m_r - 1) >= N) begin
                q_stb[(cyc + 2) % 4] = 1'b1;
                for (int c = 0; c < CH; c++)
                    q_val[(cyc + 2) % 4][c] = model_lane(c, n_acc - 1);
            end
        end
        e_stb = q_stb[now];
        if (e_stb) begin
            m_settling = 1'b0;
            for (int c = 0; c < CH; c++) m_out[c] = q_val[now][c];
        end
        q_stb[now] = 1'b0;
        @(posedge clock);
        #1;
        chk("out_strobe", 64'(out_strobe), 64'(e_stb));
        chk("settling",   64'(settling),   64'(m_settling));
        chk("dec_active", 64'(dec_active), 64'(m_r));
        chk("out_data0",  lane(0), m_out[0]);
        chk("out_data1",  lane(1), m_out[1]);
        cyc++;
    endtask

    task automatic run_dc(input int dec, input int v0, input int v1, input int gap, input int ns);
        for (int s = 0; s < ns; s++) begin
            step(1'b0, dec, 1'b1, v0, v1);
            for (int g = 1; g < gap; g++) step(1'b0, dec, 1'b0, v0, v1);
        end
    endtask

    task automatic run_rand(input int dec, input int ncyc, input int dens, input int amp);
        for (int i = 0; i < ncyc; i++)
            step(1'b0, dec, ($urandom_range(99) < dens),
                 int'($urandom_range(2*amp)) - amp, int'($urandom_range(2*amp)) - amp);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) q_stb[i] = 1'b0;
        for (int c = 0; c < CH; c++) m_out[c] = 0;
        repeat (3) step(1'b1, 4, 1'b0, 0, 0);

        // DC at R=4, one sample every 4th clock
        run_dc(4, 1000, -1000, 4, 100);
        chk("r4_dc_ch0", lane(0), 1000);
        chk("r4_dc_ch1", lane(1), -1000);

        // mid-stream change to R=8; the coinciding strobe is dropped
        step(1'b0, 8, 1'b1, 1000, -1000);
        chk("chg_settling", 64'(settling), 1);
        chk("chg_dec", 64'(dec_active), 8);
        run_dc(8, 1000, -1000, 1, 200);
        chk("r8_dc_ch0", lane(0), 1000);

        // non-power-of-2 gain
        run_dc(5, 1000, 1000, 1, 200);
        chk("r5_dc_ch0", lane(0), 95);
        chk("r5_dc_ch1", lane(1), 95);

        // R=1 pass-through with random full-scale data
        run_rand(1, 300, 100, 131071);

        // full-scale DC with long runs so the integrators wrap
        run_dc(8, 131071, -131072, 1, 400);
        chk("max_ch0", lane(0), 131071);
        chk("max_ch1", lane(1), -131072);
        run_dc(8, -131072, 131071, 1, 400);
        chk("min_ch0", lane(0), -131072);
        chk("min_ch1", lane(1), 131071);

        for (int seg = 0; seg < 6; seg++)
            run_rand(int'($urandom_range(16, 1)), 400, int'($urandom_range(100, 20)), 131071);

        // idle at R=0, then restart
        run_rand(0, 60, 50, 1000);
        chk("idle_settling", 64'(settling), 1);
        run_rand(3, 150, 70, 50000);

        // reset coinciding with an input strobe
        run_dc(2, 500, -500, 1, 40);
        step(1'b1, 2, 1'b1, 500, -500);
        chk("rst_out_data", 64'(out_data), 0);
        chk("rst_settling", 64'(settling), 1);
        chk("rst_dec", 64'(dec_active), 0);
        run_dc(2, 500, -500, 1, 60);
        chk("post_rst_ch0", lane(0), 500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/varcic_mc.md
Name: varcic_mc

Overview:
- Multi-channel, runtime-variable CIC decimator for the receive path, sitting between the CORDIC/mixer output and the FIR/packetiser stage.
- Generalises the fixed-table variable CIC in several ways:
  - any decimation 1..2^DEC_WIDTH-1;
  - CHANNELS lanes sharing one strobe and counter (I/Q or multiple receivers);
  - automatic output shift from the decimation value;
  - round-half-up with saturation;
  - safe flush and warm-up on decimation change.

Parameters:
- STAGES, 5, integrator/comb pair count N.
- IN_WIDTH, 18, signed input width per channel.
- OUT_WIDTH, 18, signed output width per channel.
- DEC_WIDTH, 6, width of decimation input.
- ACC_WIDTH, 48, accumulator width; must be >= IN_WIDTH + STAGES*DEC_WIDTH (elaboration error otherwise).
- CHANNELS, 2, parallel lanes.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- decimation  in  DEC_WIDTH  requested decimation R, unsigned
- in_strobe  in  1  input sample valid, one cycle per sample
- in_data  in  CHANNELS*IN_WIDTH  packed signed samples, channel 0 in LSBs
- out_strobe  out  1  output sample valid, one cycle
- out_data  out  CHANNELS*OUT_WIDTH  packed signed outputs, channel 0 in LSBs
- dec_active  out  DEC_WIDTH  decimation currently in effect
- settling  out  1  high during flush/warm-up, outputs suppressed

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: integrators, combs and comb delays 0; sample counter 0; out_strobe 0; out_data 0; dec_active 0; settling 1; warm-up count 0.
- Decimation latch:
  - dec_active loads decimation on the first cycle after reset.
  - Any later cycle where decimation != dec_active triggers a flush in the same cycle: clear all integrators/combs/counter, load dec_active, set settling, zero the warm-up count.
  - A concurrent in_strobe is discarded.
- R=0: block idle. No counting, no out_strobe, settling=1. Leaving 0 flushes as above.
- Integrators: stage k updates on in_strobe only: acc_k <= acc_k + acc_(k-1), each stage registered. Wrap-around (two's complement, ACC_WIDTH) is intentional and required.
- Counter:
  - Increments on in_strobe.
  - On the in_strobe where count == dec_active-1, count returns to 0 and comb_strobe pulses next cycle.
  - R=1 pulses on every in_strobe.
- Combs: each stage registered on comb_strobe: y_k <= x_k - x_k_delayed, with differential delay 1 (one decimated sample).
- Shift: SHIFT = STAGES * ceil(log2(dec_active)), computed combinationally from dec_active (priority encoder; R=1 -> 0).
  - Gain is exactly 1 for power-of-2 R and < 1 otherwise.
  - Shift is bounded by ACC_WIDTH.
- Rounding stage (one cycle after comb_strobe):
  - Arithmetic-shift comb output right by SHIFT, then add bit SHIFT-1 (no add when SHIFT=0).
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Latency: out_strobe and out_data are registered together, 2 clocks after the qualifying in_strobe. out_data holds between strobes.
- Warm-up: the first STAGES rounding results after reset/flush are suppressed (out_strobe stays 0, out_data not updated). settling drops in the same cycle as the first asserted out_strobe.
- Channels: all lanes share counter, strobes and shift; the arithmetic of each lane is independent.
- in_strobe on consecutive clocks is legal. Throughput is 1 sample/clock for any R.

Test Plan:
- Reset, R=4, STAGES=5, DC 1000 on ch0 / -1000 on ch1, in_strobe every 4th clock:
  - first 5 decimated results suppressed, settling=1;
  - outputs then converge to exactly 1000 / -1000 and hold;
  - out_strobe period 16 clocks, 2 clocks after each 4th in_strobe.
- R=5, DC 1000: SHIFT=15; steady output round(1000*3125/32768) = 95.
- R=1, random inputs every clock, after warm-up: out_data equals in_data delayed 2 clocks (plus integrator pipeline), out_strobe continuous.
- Mid-stream change 4 -> 8 with DC 1000 running:
  - immediate flush, settling=1, dec_active=8;
  - 5 suppressed outputs, then 1000 steady;
  - no stale sample emitted.
- Max-scale DC 131071 at R=8, then -131072:
  - outputs 131071 / -131072, no overflow;
  - integrators wrap over a long run without corrupting the output.
- reset asserted mid-block and on a cycle coinciding with in_strobe: all outputs at reset values the next cycle; settling=1; the strobe is ignored.
